exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/interrupt arbiter sitting directly upstream of cp0, at the MEM-stage commit point.
- Collects the per-instruction exception cause vector, pending interrupts and ERET from the committing instruction, and selects one event.
- Drives cp0's exception-write port (en_exp_i, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we, exp_asid, exp_asid_we, clean_exl).
- Redirects and flushes the pipeline to the computed vector or EPC.

Parameters:
- FLUSH_CYCLES, 2: number of cycles flush is held after an event (1..15).
- BOOT_BASE, 32'hBFC00200: exception base used when BEV=1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  committing instruction valid (0 = bubble)
- mem_pc  in  32  PC of committing instruction
- mem_bd  in  1  instruction is in a branch delay slot
- mem_exc  in  11  cause bits [0]AdEL-IF [1]TLBL-IF [2]TLBrefill-IF [3]RI [4]Sys [5]Bp [6]Ov [7]AdEL-D [8]AdES-D [9]TLBL-D [10]TLBS-D
- mem_tlb_mod  in  1  TLB modified fault on store
- mem_data_refill  in  1  data TLB fault is a refill (no matching entry)
- mem_badv_data  in  32  data access address
- mem_is_eret  in  1  committing instruction is ERET
- hardware_int  in  6  raw hardware interrupt lines
- software_int  in  2  Cause.IP[1:0] from cp0
- interrupt_mask  in  8  Status.IM from cp0
- allow_int  in  1  IE=1, EXL=0, ERL=0 from cp0
- in_exl  in  1  Status.EXL
- boot_exp_vec  in  1  Status.BEV
- special_int_vec  in  1  Cause.IV
- ebase  in  20  {2'b10, EBase[29:12]}
- epc  in  32  current EPC
- asid  in  8  current EntryHi.ASID
- en_exp  out  1  exception commit pulse to cp0
- exp_epc  out  32
- exp_bd  out  1
- exp_code  out  5
- exp_bad_vaddr  out  32
- exp_badv_we  out  1
- exp_asid  out  8
- exp_asid_we  out  1
- clean_exl  out  1  ERET commit pulse
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32

Behaviour:
- Reset: all outputs 0, FSM in IDLE, flush counter 0, synchroniser flops 0.
- Interrupt pending: allow_int & |(interrupt_mask & {hw_int_s, software_int}); hw_int_s is the (optionally synchronised) hardware_int.
- Events are evaluated only when state==IDLE and mem_valid=1.
- Priority (highest first): interrupt(0), AdEL-IF(4), TLBL-IF refill or invalid(2), RI(10), Sys(8), Bp(9), Ov(12), AdEL-D(4), AdES-D(5), TLBL-D(2), TLBS-D(3), Mod(1), ERET.
  - Exceptions always beat ERET, including an ERET that itself faults.
- Exception outputs:
  - exp_epc = mem_bd ? mem_pc-32'd4 : mem_pc (mod 2^32); exp_bd = mem_bd.
  - exp_bad_vaddr = mem_pc for IF causes, mem_badv_data for data causes.
  - exp_badv_we = 1 only for address-error and TLB causes (never for interrupt, RI, Sys, Bp or Ov).
  - exp_asid = asid; exp_asid_we = 1 for TLB causes.
- Vector:
  - base = boot_exp_vec ? BOOT_BASE : {ebase,12'h000}.
  - offset = 0x000 for a TLB refill while in_exl=0; 0x200 for an interrupt while special_int_vec=1; otherwise 0x180.
  - redirect_pc = base+offset.
- ERET: clean_exl=1, redirect_pc=epc.
- Latency: event detected in cycle N produces registered outputs in cycle N+1.
  - en_exp / clean_exl / redirect_valid are pulses of exactly one cycle.
  - flush is asserted for FLUSH_CYCLES consecutive cycles starting at N+1.
- FSM:
  - IDLE -> FLUSH on any event; counter loads FLUSH_CYCLES-1.
  - FLUSH decrements the counter; FLUSH -> IDLE when counter==0.
  - Inputs are ignored in FLUSH; a pending interrupt stays visible and is taken on the next valid instruction after returning to IDLE.
- Bubble (mem_valid=0): no event, even with an interrupt pending.
- Reset asserted mid-FLUSH: next cycle IDLE, all outputs 0.

Optional Feature:
- EXC_HWINT_SYNC_EN
  - Defined: hardware_int passes through a 2-flop synchroniser (flops reset to 0), adding 2 cycles of interrupt latency.
  - Undefined: hardware_int is used combinationally; no synchroniser flops exist.

Decomposition:
- Package exc_pkg:
  - 5-bit ExcCode constants (INT, MOD, TLBL, TLBS, ADEL, ADES, SYS, BP, RI, OV).
  - mem_exc bit-index constants.
  - Vector offset constants (0x000, 0x180, 0x200).
- Sub-module exc_prio_enc: purely combinational priority encoder.
  - Inputs: int pending, mem_exc, mem_tlb_mod, mem_is_eret.
  - Outputs: any_exc, code, is_if, badv_we, asid_we, is_refill, is_eret.
- exc_ctrl holds the registers and the FSM.

Test Plan:
- mem_valid=1, mem_exc[4]=1, mem_pc=32'h80001000, mem_bd=0, BEV=0, ebase=20'h80000 -> next cycle en_exp=1, exp_code=8, exp_epc=32'h80001000, redirect_pc=32'h80000180; flush high for 2 cycles.
- mem_bd=1, mem_pc=32'h80002004, mem_exc[7]=1, mem_badv_data=32'h00000003 -> exp_code=4, exp_epc=32'h80002000, exp_bd=1, exp_bad_vaddr=32'h3, exp_badv_we=1.
- allow_int=1, interrupt_mask=8'h80, hardware_int=6'h20 with macro defined -> interrupt taken on the 3rd valid cycle; exp_code=0; with IV=1, redirect_pc=32'h80000200.
- mem_exc[2]=1, in_exl=0, BEV=1 -> redirect_pc=32'hBFC00200, exp_code=2, exp_asid_we=1; repeat with in_exl=1 -> redirect_pc=32'hBFC00380.
- ERET alone with epc=32'h80004000 -> clean_exl=1, en_exp=0, redirect_pc=32'h80004000; ERET with mem_exc[0]=1 -> en_exp=1, exp_code=4, clean_exl=0.
- Event, then rst=1 in the first flush cycle -> next cycle flush=0, all outputs 0; a second event offered during FLUSH is ignored (no second en_exp).

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: ExcCodes, mem_exc bit positions, vector offsets and FSM states for exc_ctrl
package exc_pkg;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int B_ADEL_IF   = 0;
    localparam int B_TLBL_IF   = 1;
    localparam int B_REFILL_IF = 2;
    localparam int B_RI        = 3;
    localparam int B_SYS       = 4;
    localparam int B_BP        = 5;
    localparam int B_OV        = 6;
    localparam int B_ADEL_D    = 7;
    localparam int B_ADES_D    = 8;
    localparam int B_TLBL_D    = 9;
    localparam int B_TLBS_D    = 10;

    localparam logic [11:0] VEC_REFILL = 12'h000;
    localparam logic [11:0] VEC_GEN    = 12'h180;
    localparam logic [11:0] VEC_INT    = 12'h200;

    typedef enum logic {IDLE, FLUSH} state_t;
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage commit inputs, cp0 status inputs, cp0 exception-write and redirect outputs
interface exc_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [10:0] mem_exc;
    logic        mem_tlb_mod;
    logic        mem_data_refill;
    logic [31:0] mem_badv_data;
    logic        mem_is_eret;
    logic [5:0]  hardware_int;
    logic [1:0]  software_int;
    logic [7:0]  interrupt_mask;
    logic        allow_int;
    logic        in_exl;
    logic        boot_exp_vec;
    logic        special_int_vec;
    logic [19:0] ebase;
    logic [31:0] epc;
    logic [7:0]  asid;
    logic        en_exp;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad_vaddr;
    logic        exp_badv_we;
    logic [7:0]  exp_asid;
    logic        exp_asid_we;
    logic        clean_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  mem_valid, mem_pc, mem_bd, mem_exc, mem_tlb_mod, mem_data_refill, mem_badv_data,
               mem_is_eret, hardware_int, software_int, interrupt_mask, allow_int, in_exl,
               boot_exp_vec, special_int_vec, ebase, epc, asid,
        output en_exp, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we, exp_asid,
               exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc
    );
    modport master (
        output mem_valid, mem_pc, mem_bd, mem_exc, mem_tlb_mod, mem_data_refill, mem_badv_data,
               mem_is_eret, hardware_int, software_int, interrupt_mask, allow_int, in_exl,
               boot_exp_vec, special_int_vec, ebase, epc, asid,
        input  en_exp, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we, exp_asid,
               exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational selection of the highest-priority exception, ERET only when nothing faults
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic        int_pend,
    input  logic [10:0] exc,
    input  logic        tlb_mod,
    input  logic        data_refill,
    input  logic        eret,
    output logic        any_exc,
    output logic [4:0]  code,
    output logic        is_if,
    output logic        badv_we,
    output logic        asid_we,
    output logic        is_refill,
    output logic        is_eret
);
    // priority chain, interrupt first, Mod last
    always_comb begin
        any_exc = 1'b1;
        code = EXC_INT;
        is_if = 1'b0;
        badv_we = 1'b0;
        asid_we = 1'b0;
        is_refill = 1'b0;
        if (int_pend) code = EXC_INT;
        else if (exc[B_ADEL_IF]) begin
            code = EXC_ADEL;
            is_if = 1'b1;
            badv_we = 1'b1;
        end else if (exc[B_TLBL_IF] | exc[B_REFILL_IF]) begin
            code = EXC_TLBL;
            is_if = 1'b1;
            badv_we = 1'b1;
            asid_we = 1'b1;
            is_refill = exc[B_REFILL_IF];
        end else if (exc[B_RI]) code = EXC_RI;
        else if (exc[B_SYS]) code = EXC_SYS;
        else if (exc[B_BP]) code = EXC_BP;
        else if (exc[B_OV]) code = EXC_OV;
        else if (exc[B_ADEL_D]) begin
            code = EXC_ADEL;
            badv_we = 1'b1;
        end else if (exc[B_ADES_D]) begin
            code = EXC_ADES;
            badv_we = 1'b1;
        end else if (exc[B_TLBL_D] | exc[B_TLBS_D]) begin
            code = exc[B_TLBL_D] ? EXC_TLBL : EXC_TLBS;
            badv_we = 1'b1;
            asid_we = 1'b1;
            is_refill = data_refill;
        end else if (tlb_mod) begin
            code = EXC_MOD;
            badv_we = 1'b1;
            asid_we = 1'b1;
        end else any_exc = 1'b0;
    end

    assign is_eret = eret & ~any_exc;
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt arbiter feeding cp0; EXC_HWINT_SYNC_EN adds a 2-flop hardware_int synchroniser
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] BOOT_BASE    = 32'hBFC00200
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        flush_n;
    logic [5:0]  hw_int_s;
    logic        int_pend, any_exc, is_if, badv_we, asid_we, is_refill, is_eret;
    logic [4:0]  code;
    logic        take, exc_ev, eret_ev;
    logic [31:0] base, vec;
    logic [11:0] offset;

`ifdef EXC_HWINT_SYNC_EN
    logic [5:0] hw_s1, hw_s2;
    // two-stage synchroniser for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (rst) {hw_s2, hw_s1} <= '0;
        else {hw_s2, hw_s1} <= {hw_s1, bus.hardware_int};
    end
    assign hw_int_s = hw_s2;
`else
    assign hw_int_s = bus.hardware_int;
`endif

    assign int_pend = bus.allow_int & |(bus.interrupt_mask & {hw_int_s, bus.software_int});

    exc_prio_enc u_enc (
        .int_pend   (int_pend),
        .exc        (bus.mem_exc),
        .tlb_mod    (bus.mem_tlb_mod),
        .data_refill(bus.mem_data_refill),
        .eret       (bus.mem_is_eret),
        .any_exc    (any_exc),
        .code       (code),
        .is_if      (is_if),
        .badv_we    (badv_we),
        .asid_we    (asid_we),
        .is_refill  (is_refill),
        .is_eret    (is_eret)
    );

    assign take    = (state == IDLE) & bus.mem_valid;
    assign exc_ev  = take & any_exc;
    assign eret_ev = take & is_eret;
    assign base    = bus.boot_exp_vec ? BOOT_BASE : {bus.ebase, 12'h000};
    assign offset  = (is_refill & ~bus.in_exl) ? VEC_REFILL :
                     (int_pend & bus.special_int_vec) ? VEC_INT : VEC_GEN;
    assign vec     = base + {20'h0, offset};

    // next state: an event starts a flush window, the counter walks it down to IDLE
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        flush_n = 1'b0;
        if (state == IDLE) begin
            if (exc_ev | eret_ev) begin
                state_n = FLUSH;
                cnt_n = CNT_INIT;
                flush_n = 1'b1;
            end
        end else if (cnt == 4'd0) state_n = IDLE;
        else begin
            cnt_n = cnt - 4'd1;
            flush_n = 1'b1;
        end
    end

    // state register and registered cp0/redirect outputs, zero whenever no event was taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus.flush <= 1'b0;
            bus.en_exp <= 1'b0;
            bus.clean_exl <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc <= '0;
            bus.exp_epc <= '0;
            bus.exp_bd <= 1'b0;
            bus.exp_code <= '0;
            bus.exp_bad_vaddr <= '0;
            bus.exp_badv_we <= 1'b0;
            bus.exp_asid <= '0;
            bus.exp_asid_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bus.flush <= flush_n;
            bus.en_exp <= exc_ev;
            bus.clean_exl <= eret_ev;
            bus.redirect_valid <= exc_ev | eret_ev;
            bus.redirect_pc <= exc_ev ? vec : eret_ev ? bus.epc : '0;
            bus.exp_epc <= exc_ev ? (bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc) : '0;
            bus.exp_bd <= exc_ev & bus.mem_bd;
            bus.exp_code <= exc_ev ? code : '0;
            bus.exp_bad_vaddr <= (exc_ev & badv_we) ? (is_if ? bus.mem_pc : bus.mem_badv_data) : '0;
            bus.exp_badv_we <= exc_ev & badv_we;
            bus.exp_asid <= exc_ev ? bus.asid : '0;
            bus.exp_asid_we <= exc_ev & asid_we;
        end
    end
endmodule
